controle_interrupcao: RTL and testbench

Interrupt controller that produces the saved return PC and the interrupt identifier later read back by the processor's PC/interrupt data-path selector. It latches request edges, arbitrates by fixed priority at instruction boundaries, and saves the return PC. It then requests the jump to the service routine and handles return-from-interrupt. There is a single nesting level.

---
 rtl/controle_interrupcao_pkg.sv | 13 +
 rtl/controle_interrupcao_codificador_prioridade.sv | 25 ++
 rtl/controle_interrupcao.sv | 78 +++++++
 tb/tb_controle_interrupcao.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/controle_interrupcao_pkg.sv
// controle_interrupcao_pkg: shared state encoding and id sizing for the interrupt controller
package controle_interrupcao_pkg;
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESVIO  = 2'd1,
    EM_ISR  = 2'd2,
    RETORNO = 2'd3
  } estado_t;
  localparam int ID_NENHUMA = 0;
  function automatic int id_width(input int num_irq);
    return $clog2(num_irq + 1);
  endfunction
endpackage

// File: rtl/controle_interrupcao_codificador_prioridade.sv
// codificador_prioridade: fixed-priority encoder, lowest set index wins
module codificador_prioridade
  import controle_interrupcao_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 3
) (
  input  logic [NUM_IRQ-1:0] pedidos,
  output logic               valido,
  output logic [ID_W-1:0]    indice,
  output logic [NUM_IRQ-1:0] mascara
);
  always_comb begin
    valido  = |pedidos;
    indice  = ID_W'(ID_NENHUMA);
    mascara = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pedidos[i]) begin
        indice     = ID_W'(i);
        mascara    = '0;
        mascara[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/controle_interrupcao.sv
// controle_interrupcao: edge-latched, fixed-priority, single-level interrupt controller
module controle_interrupcao
  import controle_interrupcao_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 13,
  parameter int                  NUM_IRQ    = 4,
  parameter logic [ADDR_WIDTH-1:0] ISR_BASE = 'h0010
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_IRQ-1:0]    irq,
  input  logic                  habilita_int,
  input  logic                  instr_fim,
  input  logic [ADDR_WIDTH-1:0] valor_pc,
  input  logic                  reti,
  output logic                  desvio_isr,
  output logic [ADDR_WIDTH-1:0] endereco_isr,
  output logic [ADDR_WIDTH-1:0] pc_interrup,
  output logic [DATA_WIDTH-1:0] qual_interrupcao,
  output logic                  em_interrupcao,
  output logic                  retorno,
  output logic [NUM_IRQ-1:0]    pendentes
);
  localparam int ID_W = id_width(NUM_IRQ);
  estado_t               estado_q, estado_d;
  logic [NUM_IRQ-1:0]    pend_q, pend_d;
  logic [NUM_IRQ-1:0]    irq_ant_q;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ID_W-1:0]       qual_q, qual_d;
  logic                  valido, aceita;
  logic [ID_W-1:0]       indice;
  logic [NUM_IRQ-1:0]    mascara, limpa;
  codificador_prioridade #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_prio (
    .pedidos(pend_q),
    .valido (valido),
    .indice (indice),
    .mascara(mascara)
  );
  // arbitration uses registered pending bits, so irq never reaches outputs combinationally
  always_comb begin
    aceita   = (estado_q == OCIOSO) && habilita_int && instr_fim && valido;
    limpa    = aceita ? mascara : '0;
    pend_d   = (pend_q & ~limpa) | (irq & ~irq_ant_q);
    pc_d     = aceita ? valor_pc : pc_q;
    qual_d   = aceita ? indice + ID_W'(1) : (estado_q == RETORNO) ? ID_W'(ID_NENHUMA) : qual_q;
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:  estado_d = aceita ? DESVIO : OCIOSO;
      DESVIO:  estado_d = EM_ISR;
      EM_ISR:  estado_d = reti ? RETORNO : EM_ISR;
      RETORNO: estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      pend_q    <= '0;
      irq_ant_q <= '0;
      pc_q      <= '0;
      qual_q    <= '0;
    end else begin
      estado_q  <= estado_d;
      pend_q    <= pend_d;
      irq_ant_q <= irq;
      pc_q      <= pc_d;
      qual_q    <= qual_d;
    end
  end
  assign desvio_isr       = estado_q == DESVIO;
  assign retorno          = estado_q == RETORNO;
  assign em_interrupcao   = estado_q != OCIOSO;
  assign endereco_isr     = ISR_BASE;
  assign pc_interrup      = pc_q;
  assign qual_interrupcao = DATA_WIDTH'(qual_q);
  assign pendentes        = pend_q;
endmodule

// File: tb/tb_controle_interrupcao.sv
// tb_controle_interrupcao: directed stimulus with a pulse scoreboard for desvio_isr/retorno
module tb_controle_interrupcao;
  logic        clock = 1'b0;
  logic        reset, habilita_int, instr_fim, reti;
  logic [3:0]  irq;
  logic [12:0] valor_pc;
  logic        desvio_isr, em_interrupcao, retorno;
  logic [12:0] endereco_isr, pc_interrup;
  logic [31:0] qual_interrupcao;
  logic [3:0]  pendentes;
  typedef struct {bit desvio; logic [12:0] pc; logic [31:0] qual;} ev_t;
  ev_t fila[$];
  int checks = 0;
  int failures = 0;
  always #5 clock = ~clock;
  controle_interrupcao dut (
    .clock(clock), .reset(reset), .irq(irq), .habilita_int(habilita_int),
    .instr_fim(instr_fim), .valor_pc(valor_pc), .reti(reti),
    .desvio_isr(desvio_isr), .endereco_isr(endereco_isr), .pc_interrup(pc_interrup),
    .qual_interrupcao(qual_interrupcao), .em_interrupcao(em_interrupcao),
    .retorno(retorno), .pendentes(pendentes)
  );
  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nome, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic espera(input logic [12:0] pc, input logic [31:0] qual);
    ev_t e;
    e.desvio = 1'b1; e.pc = pc; e.qual = qual;
    fila.push_back(e);
  endtask
  task automatic servico_fim(input logic [12:0] pc);
    ev_t e;
    e.desvio = 1'b0; e.pc = pc; e.qual = 32'd0;
    fila.push_back(e);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
    chk("qual_cleared", qual_interrupcao, 32'd0);
    chk("em_idle", {31'd0, em_interrupcao}, 32'd0);
  endtask
  always @(negedge clock) begin
    if (!reset && (desvio_isr || retorno)) begin
      if (fila.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse desvio=%b retorno=%b exp=none", desvio_isr, retorno);
      end else begin
        ev_t e;
        e = fila.pop_front();
        chk("pulse_desvio", {31'd0, desvio_isr}, {31'd0, e.desvio});
        chk("pulse_retorno", {31'd0, retorno}, {31'd0, !e.desvio});
        chk("pulse_em", {31'd0, em_interrupcao}, 32'd1);
        chk("pulse_pc", {19'd0, pc_interrup}, {19'd0, e.pc});
        if (e.desvio) chk("pulse_qual", qual_interrupcao, e.qual);
      end
    end
  end
  initial begin
    reset = 1'b1; irq = '0; habilita_int = 1'b0; instr_fim = 1'b0; reti = 1'b0; valor_pc = '0;
    tick(2);
    chk("rst_pend", {28'd0, pendentes}, 32'd0);
    chk("rst_outs", {29'd0, desvio_isr, retorno, em_interrupcao}, 32'd0);
    chk("rst_qual", qual_interrupcao, 32'd0);
    chk("rst_pc", {19'd0, pc_interrup}, 32'd0);
    chk("isr_base", {19'd0, endereco_isr}, 32'h10);
    reset = 1'b0;
    // basic service of irq[2]
    tick(3);
    irq = 4'b0100; valor_pc = 13'h0123; habilita_int = 1'b1;
    tick();
    irq = '0;
    chk("t1_pend", {28'd0, pendentes}, 32'b0100);
    instr_fim = 1'b1;
    espera(13'h0123, 32'd3);
    tick();
    instr_fim = 1'b0;
    chk("t1_pend_clr", {28'd0, pendentes}, 32'd0);
    chk("t1_pc", {19'd0, pc_interrup}, 32'h0123);
    chk("t1_qual", qual_interrupcao, 32'd3);
    tick();
    chk("t1_em", {31'd0, em_interrupcao}, 32'd1);
    servico_fim(13'h0123);
    // simultaneous irq[1] and irq[3], back-to-back service
    irq = 4'b1010;
    tick();
    irq = '0;
    chk("t2_pend", {28'd0, pendentes}, 32'b1010);
    valor_pc = 13'h0200; instr_fim = 1'b1;
    espera(13'h0200, 32'd2);
    tick();
    instr_fim = 1'b0;
    chk("t2_pend_left", {28'd0, pendentes}, 32'b1000);
    tick();
    begin
      ev_t e;
      e.desvio = 1'b0; e.pc = 13'h0200; e.qual = 32'd0;
      fila.push_back(e);
    end
    reti = 1'b1;
    tick();
    reti = 1'b0; instr_fim = 1'b1; valor_pc = 13'h0300;
    tick();
    chk("t2_qual_idle", qual_interrupcao, 32'd0);
    espera(13'h0300, 32'd4);
    tick();
    instr_fim = 1'b0;
    chk("t2_qual4", qual_interrupcao, 32'd4);
    tick();
    servico_fim(13'h0300);
    // globally disabled
    habilita_int = 1'b0; irq = 4'b0001;
    tick();
    irq = '0; instr_fim = 1'b1;
    tick(10);
    chk("t3_pend_hold", {28'd0, pendentes}, 32'b0001);
    chk("t3_em", {31'd0, em_interrupcao}, 32'd0);
    habilita_int = 1'b1; valor_pc = 13'h0400;
    espera(13'h0400, 32'd1);
    tick();
    instr_fim = 1'b0;
    tick();
    // no nesting inside EM_ISR
    irq = 4'b0001; instr_fim = 1'b1; valor_pc = 13'h0555;
    tick();
    irq = '0;
    tick(2);
    instr_fim = 1'b0;
    chk("t4_pend", {28'd0, pendentes}, 32'b0001);
    chk("t4_pc", {19'd0, pc_interrup}, 32'h0400);
    chk("t4_qual", qual_interrupcao, 32'd1);
    servico_fim(13'h0400);
    valor_pc = 13'h0600; instr_fim = 1'b1;
    espera(13'h0600, 32'd1);
    tick();
    instr_fim = 1'b0;
    tick();
    servico_fim(13'h0600);
    // reset in the middle of service
    irq = 4'b1010;
    tick();
    irq = '0; valor_pc = 13'h0700; instr_fim = 1'b1;
    espera(13'h0700, 32'd2);
    tick();
    instr_fim = 1'b0;
    tick();
    irq = 4'b0010;
    tick();
    irq = '0;
    chk("t5_pend", {28'd0, pendentes}, 32'b1010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_pend_rst", {28'd0, pendentes}, 32'd0);
    chk("t5_outs", {29'd0, desvio_isr, retorno, em_interrupcao}, 32'd0);
    chk("t5_qual", qual_interrupcao, 32'd0);
    chk("t5_pc", {19'd0, pc_interrup}, 32'd0);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
    chk("t5_no_ret", {31'd0, em_interrupcao}, 32'd0);
    // held level raises a single request
    irq = 4'b0100;
    tick();
    chk("t6_pend", {28'd0, pendentes}, 32'b0100);
    valor_pc = 13'h0800; instr_fim = 1'b1;
    espera(13'h0800, 32'd3);
    tick();
    instr_fim = 1'b0;
    tick(18);
    chk("t6_no_repend", {28'd0, pendentes}, 32'd0);
    servico_fim(13'h0800);
    irq = '0;
    tick();
    irq = 4'b0001;
    tick();
    irq = '0;
    tick();
    // new edge on the winner during accept: set wins over clear
    irq = 4'b0001; instr_fim = 1'b1; valor_pc = 13'h0900;
    espera(13'h0900, 32'd1);
    tick();
    irq = '0; instr_fim = 1'b0;
    chk("t6_set_wins", {28'd0, pendentes}, 32'b0001);
    tick();
    servico_fim(13'h0900);
    valor_pc = 13'h0a00; instr_fim = 1'b1;
    espera(13'h0a00, 32'd1);
    tick();
    instr_fim = 1'b0;
    tick();
    servico_fim(13'h0a00);
    chk("t6_pend_empty", {28'd0, pendentes}, 32'd0);
    // level held through reset release counts as an edge
    reset = 1'b1; irq = 4'b0100; habilita_int = 1'b0;
    tick(2);
    reset = 1'b0;
    tick();
    chk("rst_edge", {28'd0, pendentes}, 32'b0100);
    tick(3);
    chk("queue_drained", fila.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
